// File: rtl/tcp_tx_retry_sender.sv
// Final TX stage toward the TCP offload engine: requests a TX slot, waits for status,
// sends one 64-byte beat, and on a space error backs off and retries before dropping.
//
// state       | meaning
// IDLE        | ready for the next response from the collector
// SEND_META   | presenting tx metadata until the engine takes it
// WAIT_STATUS | waiting for tx status, timer running toward timeout
// SEND_DATA   | presenting the single data beat
// BACKOFF     | quiet wait before re-issuing the same metadata
module tcp_tx_retry_sender #(
    parameter int PKT_BYTES      = 64,
    parameter int BACKOFF_CYCLES = 256,
    parameter int MAX_RETRIES    = 8,
    parameter int STATUS_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic [527:0] rx_TDATA,
    input  logic         rx_TVALID,
    output logic         rx_TREADY,
    output logic [31:0]  m_axis_tx_metadata_TDATA,
    output logic         m_axis_tx_metadata_TVALID,
    input  logic         m_axis_tx_metadata_TREADY,
    input  logic [63:0]  s_axis_tx_status_TDATA,
    input  logic         s_axis_tx_status_TVALID,
    output logic         s_axis_tx_status_TREADY,
    output logic [511:0] m_axis_tx_data_TDATA,
    output logic [63:0]  m_axis_tx_data_TKEEP,
    output logic         m_axis_tx_data_TLAST,
    output logic         m_axis_tx_data_TVALID,
    input  logic         m_axis_tx_data_TREADY,
    output logic [31:0]  sent_count,
    output logic [31:0]  drop_count
);

    localparam int TMAX = (STATUS_TIMEOUT > BACKOFF_CYCLES) ? STATUS_TIMEOUT : BACKOFF_CYCLES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int RW   = $clog2(MAX_RETRIES + 1);

    // Timer is a down-counter; both waits end on the terminal count of zero.
    // Backoff loads two less so the retried metadata appears BACKOFF_CYCLES
    // cycles after the status handshake that triggered it.
    localparam logic [TW-1:0] TO_LOAD = TW'(STATUS_TIMEOUT - 1);
    localparam logic [TW-1:0] BO_LOAD = TW'(BACKOFF_CYCLES - 2);
    localparam logic [15:0]   LEN     = 16'(PKT_BYTES);
    localparam logic [63:0]   KEEP    = (PKT_BYTES >= 64) ? {64{1'b1}}
                                                          : ((64'd1 << PKT_BYTES) - 64'd1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_META,
        WAIT_STATUS,
        SEND_DATA,
        BACKOFF
    } state_t;

    state_t        state;
    logic [527:0]  resp_q;
    logic [RW-1:0] retry;
    logic [TW-1:0] timer;

    logic [1:0]  status_err;
    logic [15:0] status_session;
    logic        status_hs;
    logic        status_ok;
    logic        space_err;
    logic        hard_err;
    logic        go_backoff;
    logic        drop_now;
    logic        unused_status;

    assign status_err     = s_axis_tx_status_TDATA[63:62];
    assign status_session = s_axis_tx_status_TDATA[15:0];
    assign unused_status  = ^s_axis_tx_status_TDATA[61:16];

    always_comb begin
        status_hs  = s_axis_tx_status_TVALID && s_axis_tx_status_TREADY;
        status_ok  = (status_err == 2'd0) && (status_session == resp_q[527:512]);
        space_err  = (status_hs && (status_err == 2'd2)) ||
                     (!status_hs && (state == WAIT_STATUS) && (timer == '0));
        hard_err   = status_hs && !status_ok && (status_err != 2'd2);
        go_backoff = space_err && (retry < RW'(MAX_RETRIES));
        drop_now   = hard_err || (space_err && (retry >= RW'(MAX_RETRIES)));
    end

    assign m_axis_tx_metadata_TDATA = {LEN, resp_q[527:512]};
    assign m_axis_tx_data_TDATA     = resp_q[511:0];
    assign m_axis_tx_data_TKEEP     = KEEP;
    assign m_axis_tx_data_TLAST     = 1'b1;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state                     <= IDLE;
            resp_q                    <= '0;
            retry                     <= '0;
            timer                     <= '0;
            rx_TREADY                 <= 1'b0;
            m_axis_tx_metadata_TVALID <= 1'b0;
            s_axis_tx_status_TREADY   <= 1'b0;
            m_axis_tx_data_TVALID     <= 1'b0;
            sent_count                <= '0;
            drop_count                <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rx_TREADY <= 1'b1;
                    if (rx_TVALID && rx_TREADY) begin
                        resp_q                    <= rx_TDATA;
                        retry                     <= '0;
                        rx_TREADY                 <= 1'b0;
                        m_axis_tx_metadata_TVALID <= 1'b1;
                        state                     <= SEND_META;
                    end
                end
                SEND_META: begin
                    if (m_axis_tx_metadata_TREADY) begin
                        m_axis_tx_metadata_TVALID <= 1'b0;
                        s_axis_tx_status_TREADY   <= 1'b1;
                        timer                     <= TO_LOAD;
                        state                     <= WAIT_STATUS;
                    end
                end
                WAIT_STATUS: begin
                    if (go_backoff) begin
                        s_axis_tx_status_TREADY <= 1'b0;
                        retry                   <= retry + 1'b1;
                        timer                   <= BO_LOAD;
                        state                   <= BACKOFF;
                    end else if (drop_now) begin
                        s_axis_tx_status_TREADY <= 1'b0;
                        drop_count              <= drop_count + 32'd1;
                        rx_TREADY               <= 1'b1;
                        state                   <= IDLE;
                    end else if (status_hs) begin
                        s_axis_tx_status_TREADY <= 1'b0;
                        m_axis_tx_data_TVALID   <= 1'b1;
                        state                   <= SEND_DATA;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SEND_DATA: begin
                    if (m_axis_tx_data_TREADY) begin
                        m_axis_tx_data_TVALID <= 1'b0;
                        sent_count            <= sent_count + 32'd1;
                        rx_TREADY             <= 1'b1;
                        state                 <= IDLE;
                    end
                end
                BACKOFF: begin
                    if (timer == '0) begin
                        m_axis_tx_metadata_TVALID <= 1'b1;
                        state                     <= SEND_META;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_tx_retry_sender.sv
// Directed bench for tcp_tx_retry_sender: happy path, backoff retry, retry exhaustion,
// hard errors, status timeout with metadata backpressure, and reset mid-operation.
module tb_tcp_tx_retry_sender;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [527:0] rx_TDATA = '0;
    logic         rx_TVALID = 1'b0;
    logic         rx_TREADY;
    logic [31:0]  meta_data;
    logic         meta_valid;
    logic         meta_ready = 1'b1;
    logic [63:0]  status_data = '0;
    logic         status_valid = 1'b0;
    logic         status_ready;
    logic [511:0] data_data;
    logic [63:0]  data_keep;
    logic         data_last;
    logic         data_valid;
    logic         data_ready = 1'b1;
    logic [31:0]  sent_count;
    logic [31:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;
    int data_beats = 0;
    int meta_hs = 0;
    int mark;

    tcp_tx_retry_sender dut (
        .clk                       (clk),
        .aresetn                   (aresetn),
        .rx_TDATA                  (rx_TDATA),
        .rx_TVALID                 (rx_TVALID),
        .rx_TREADY                 (rx_TREADY),
        .m_axis_tx_metadata_TDATA  (meta_data),
        .m_axis_tx_metadata_TVALID (meta_valid),
        .m_axis_tx_metadata_TREADY (meta_ready),
        .s_axis_tx_status_TDATA    (status_data),
        .s_axis_tx_status_TVALID   (status_valid),
        .s_axis_tx_status_TREADY   (status_ready),
        .m_axis_tx_data_TDATA      (data_data),
        .m_axis_tx_data_TKEEP      (data_keep),
        .m_axis_tx_data_TLAST      (data_last),
        .m_axis_tx_data_TVALID     (data_valid),
        .m_axis_tx_data_TREADY     (data_ready),
        .sent_count                (sent_count),
        .drop_count                (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (data_valid && data_ready) data_beats++;
        if (meta_valid && meta_ready) meta_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [15:0] s, input logic [7:0] b);
        rx_TDATA  = {s, {64{b}}};
        rx_TVALID = 1'b1;
        tick();
        rx_TVALID = 1'b0;
    endtask

    task automatic send_status(input logic [1:0] e, input logic [15:0] s);
        status_data  = {e, 30'h100, 16'd64, s};
        status_valid = 1'b1;
        tick();
        status_valid = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_meta_valid", 528'(meta_valid), 528'd0);
        chk("rst_data_valid", 528'(data_valid), 528'd0);
        chk("rst_status_ready", 528'(status_ready), 528'd0);
        chk("rst_rx_ready", 528'(rx_TREADY), 528'd0);
        chk("rst_sent", 528'(sent_count), 528'd0);
        chk("rst_drop", 528'(drop_count), 528'd0);
        aresetn = 1'b1;
        tick();
        chk("idle_rx_ready", 528'(rx_TREADY), 528'd1);

        // 1: happy path
        send_rx(16'h0005, 8'hA5);
        chk("t1_meta_valid", 528'(meta_valid), 528'd1);
        chk("t1_meta_data", 528'(meta_data), 528'h0040_0005);
        chk("t1_rx_ready_low", 528'(rx_TREADY), 528'd0);
        tick();
        chk("t1_status_ready", 528'(status_ready), 528'd1);
        chk("t1_meta_dropped", 528'(meta_valid), 528'd0);
        send_status(2'd0, 16'h0005);
        chk("t1_data_valid", 528'(data_valid), 528'd1);
        chk("t1_tkeep", 528'(data_keep), 528'({64{1'b1}}));
        chk("t1_tlast", 528'(data_last), 528'd1);
        chk("t1_tdata", 528'(data_data), 528'({64{8'hA5}}));
        tick();
        chk("t1_sent", 528'(sent_count), 528'd1);
        chk("t1_rx_ready", 528'(rx_TREADY), 528'd1);
        chk("t1_data_done", 528'(data_valid), 528'd0);

        // 2: space error then success, retry exactly 256 cycles after status
        send_rx(16'h0007, 8'h3C);
        tick();
        send_status(2'd2, 16'h0007);
        chk("t2_backoff_meta", 528'(meta_valid), 528'd0);
        chk("t2_backoff_status", 528'(status_ready), 528'd0);
        repeat (254) tick();
        chk("t2_meta_not_yet", 528'(meta_valid), 528'd0);
        tick();
        chk("t2_meta_reissue", 528'(meta_valid), 528'd1);
        chk("t2_meta_data", 528'(meta_data), 528'h0040_0007);
        tick();
        send_status(2'd0, 16'h0007);
        chk("t2_data_valid", 528'(data_valid), 528'd1);
        chk("t2_tdata", 528'(data_data), 528'({64{8'h3C}}));
        tick();
        chk("t2_sent", 528'(sent_count), 528'd2);
        chk("t2_drop", 528'(drop_count), 528'd0);
        chk("t2_beats", 528'(data_beats), 528'd2);

        // 3: retry exhaustion after 9 space errors
        chk("t3_rx_ready", 528'(rx_TREADY), 528'd1);
        mark = meta_hs;
        send_rx(16'h0009, 8'h5A);
        for (int a = 0; a < 9; a++) begin
            chk("t3_meta_valid", 528'(meta_valid), 528'd1);
            tick();
            send_status(2'd2, 16'h0009);
            if (a < 8) repeat (255) tick();
        end
        chk("t3_meta_reqs", 528'(meta_hs - mark), 528'd9);
        chk("t3_no_beat", 528'(data_beats), 528'd2);
        chk("t3_drop", 528'(drop_count), 528'd1);
        chk("t3_rx_ready_after", 528'(rx_TREADY), 528'd1);

        // 4: not-connected error, then session mismatch
        send_rx(16'h000B, 8'h11);
        tick();
        send_status(2'd1, 16'h000B);
        chk("t4_drop", 528'(drop_count), 528'd2);
        chk("t4_rx_ready", 528'(rx_TREADY), 528'd1);
        send_rx(16'h000C, 8'h22);
        chk("t4_next_meta", 528'(meta_data), 528'h0040_000C);
        chk("t4_next_valid", 528'(meta_valid), 528'd1);
        tick();
        send_status(2'd0, 16'h000D);
        chk("t4_mismatch_drop", 528'(drop_count), 528'd3);
        chk("t4_no_beat", 528'(data_beats), 528'd2);
        chk("t4_mismatch_rx", 528'(rx_TREADY), 528'd1);

        // 5: status timeout, then metadata backpressure on the retry
        send_rx(16'h0011, 8'h77);
        tick();
        repeat (4095) tick();
        chk("t5_still_waiting", 528'(status_ready), 528'd1);
        tick();
        chk("t5_backoff_status", 528'(status_ready), 528'd0);
        chk("t5_backoff_meta", 528'(meta_valid), 528'd0);
        meta_ready = 1'b0;
        repeat (255) tick();
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_valid", 528'(meta_valid), 528'd1);
            chk("t5_hold_data", 528'(meta_data), 528'h0040_0011);
            tick();
        end
        meta_ready = 1'b1;
        tick();
        chk("t5_wait_status", 528'(status_ready), 528'd1);
        send_status(2'd0, 16'h0011);
        chk("t5_tdata", 528'(data_data), 528'({64{8'h77}}));
        tick();
        chk("t5_sent", 528'(sent_count), 528'd3);

        // 6a: reset while in BACKOFF
        send_rx(16'h0021, 8'h99);
        tick();
        send_status(2'd2, 16'h0021);
        repeat (10) tick();
        aresetn = 1'b0;
        tick();
        chk("t6a_meta_valid", 528'(meta_valid), 528'd0);
        chk("t6a_status_ready", 528'(status_ready), 528'd0);
        chk("t6a_sent", 528'(sent_count), 528'd0);
        chk("t6a_drop", 528'(drop_count), 528'd0);
        mark = meta_hs;
        aresetn = 1'b1;
        repeat (300) tick();
        chk("t6a_no_retry", 528'(meta_hs - mark), 528'd0);
        chk("t6a_idle", 528'(rx_TREADY), 528'd1);

        // 6b: reset while in SEND_DATA under backpressure
        data_ready = 1'b0;
        send_rx(16'h0022, 8'h55);
        tick();
        send_status(2'd0, 16'h0022);
        chk("t6b_data_valid", 528'(data_valid), 528'd1);
        repeat (3) tick();
        chk("t6b_data_held", 528'(data_valid), 528'd1);
        chk("t6b_tdata_held", 528'(data_data), 528'({64{8'h55}}));
        mark = data_beats;
        aresetn = 1'b0;
        tick();
        data_ready = 1'b1;
        chk("t6b_data_cleared", 528'(data_valid), 528'd0);
        chk("t6b_sent", 528'(sent_count), 528'd0);
        aresetn = 1'b1;
        repeat (20) tick();
        chk("t6b_not_emitted", 528'(data_beats - mark), 528'd0);
        chk("t6b_idle", 528'(rx_TREADY), 528'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
